// File: rtl/serializer_stream.sv
// Frame-to-word serializer: one active frame plus one pending frame, ready/valid on both sides.
// Emits up to NUM_WORDS words per frame, LSW-first or MSW-first, with zero bubbles between frames.
module serializer_stream #(
  parameter  int WIDTH         = 8,
  parameter  int NUM_WORDS     = 4,
  parameter  int LITTLE_ENDIAN = 1,
  localparam int NW            = $clog2(NUM_WORDS + 1)
) (
  input  logic                       clk,
  input  logic                       i_reset_n,
  input  logic [WIDTH*NUM_WORDS-1:0] i_data,
  input  logic [NW-1:0]              i_nwords,
  input  logic                       i_dv,
  output logic                       o_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_dv,
  output logic                       o_last,
  input  logic                       i_ready,
  output logic                       o_busy
);
  localparam int            DW   = WIDTH * NUM_WORDS;
  localparam logic [NW-1:0] MAXN = NW'(NUM_WORDS);
  localparam logic [NW-1:0] ONE  = NW'(1);

  logic [DW-1:0]    r_sh;
  logic [NW-1:0]    r_left;
  logic [DW-1:0]    r_pend_data;
  logic [NW-1:0]    r_pend_n;
  logic             r_pend_valid;
  logic             r_ready;
  logic [WIDTH-1:0] r_data;
  logic             r_dv;
  logic             r_last;

  logic             w_xfer, w_last_xfer, w_accept;
  logic             w_load_pend, w_load_in, w_to_pend, w_pend_nxt;
  logic [NW-1:0]    w_in_n, w_ld_n;
  logic [DW-1:0]    w_ld_data, w_aligned, w_ld_rest, w_nx_rest;
  logic [WIDTH-1:0] w_ld_first, w_nx_data;

  always_comb begin
    w_in_n      = (i_nwords == '0 || i_nwords > MAXN) ? MAXN : i_nwords;
    w_xfer      = r_dv & i_ready;
    w_last_xfer = w_xfer & r_last;
    w_accept    = i_dv & r_ready;
    w_load_pend = w_last_xfer & r_pend_valid;
    w_load_in   = w_accept & (~r_dv | w_last_xfer) & ~r_pend_valid;
    w_to_pend   = w_accept & ~w_load_in;
    w_pend_nxt  = w_to_pend | (r_pend_valid & ~w_load_pend);
    w_ld_data   = w_load_pend ? r_pend_data : i_data;
    w_ld_n      = w_load_pend ? r_pend_n : w_in_n;
    // MSW-first: left-justify the valid words so the next word is always at the top
    if (LITTLE_ENDIAN != 0) begin
      w_aligned  = w_ld_data;
      w_ld_first = w_aligned[WIDTH-1:0];
      w_ld_rest  = w_aligned >> WIDTH;
      w_nx_data  = r_sh[WIDTH-1:0];
      w_nx_rest  = r_sh >> WIDTH;
    end else begin
      w_aligned  = w_ld_data << (WIDTH * (NUM_WORDS - int'(w_ld_n)));
      w_ld_first = w_aligned[DW-1 -: WIDTH];
      w_ld_rest  = w_aligned << WIDTH;
      w_nx_data  = r_sh[DW-1 -: WIDTH];
      w_nx_rest  = r_sh << WIDTH;
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sh         <= '0;
      r_left       <= '0;
      r_pend_data  <= '0;
      r_pend_n     <= '0;
      r_pend_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_data       <= '0;
      r_dv         <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      r_ready      <= ~w_pend_nxt;
      r_pend_valid <= w_pend_nxt;
      if (w_to_pend) begin
        r_pend_data <= i_data;
        r_pend_n    <= w_in_n;
      end
      if (w_load_pend || w_load_in) begin
        r_dv   <= 1'b1;
        r_data <= w_ld_first;
        r_sh   <= w_ld_rest;
        r_left <= w_ld_n - ONE;
        r_last <= (w_ld_n == ONE);
      end else if (w_last_xfer) begin
        r_dv   <= 1'b0;
        r_last <= 1'b0;
      end else if (w_xfer) begin
        r_data <= w_nx_data;
        r_sh   <= w_nx_rest;
        r_left <= r_left - ONE;
        r_last <= (r_left == ONE);
      end
    end
  end

  assign o_ready = r_ready;
  assign o_data  = r_data;
  assign o_dv    = r_dv;
  assign o_last  = r_last;
  assign o_busy  = r_dv | r_pend_valid;

endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
- Parametrised successor to the team's fixed-length parallel-to-serial serializer.
- Takes one frame of up to NUM_WORDS words of WIDTH bits and emits it one word per cycle, LSW-first or MSW-first.
- Supports variable frame length, ready/valid backpressure on both sides, and a one-frame pending buffer so back-to-back frames stream with no idle cycles.
- Sits between register/packet builders and narrow byte-stream links (UART/SPI framers).

Parameters:
- WIDTH, 8, bits per output word.
- NUM_WORDS, 4, maximum words per frame (>=2).
- LITTLE_ENDIAN, 1, 1 = word 0 (LSW) sent first; 0 = highest valid word sent first.

Ports:
- clk  input  1  clock, all logic on rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_data  input  WIDTH*NUM_WORDS  frame data; word k = i_data[k*WIDTH +: WIDTH].
- i_nwords  input  $clog2(NUM_WORDS+1)  valid words in frame; occupies words 0..n-1.
- i_dv  input  1  input frame valid.
- o_ready  output  1  input side can accept a frame this cycle.
- o_data  output  WIDTH  current serial word.
- o_dv  output  1  o_data valid.
- o_last  output  1  o_data is the final word of its frame.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_busy  output  1  active or pending frame held.

Behaviour:
- Reset (i_reset_n low, async):
  - o_dv, o_last, o_busy, o_data = 0.
  - o_ready = 0.
  - Active and pending buffers cleared.
  - First rising edge after release sets o_ready = 1.
  - Reset mid-frame discards all held words; no partial word or o_last is emitted afterwards.
- Frame acceptance:
  - A frame is accepted on an edge where i_dv && o_ready.
  - i_data and i_nwords are sampled only then.
- Length rules:
  - i_nwords = 0 or > NUM_WORDS is treated as NUM_WORDS.
  - Effective length n is in 1..NUM_WORDS.
- Storage: active shift register plus word counter, and one pending frame register.
- o_ready:
  - Registered, equal to !pending_valid.
  - Goes low the cycle after the pending buffer fills.
  - Goes high the cycle after pending moves to active.
- Accept routing:
  - If active is empty, or active's last word handshakes this same edge and pending is empty, the frame loads active directly.
  - Otherwise the frame loads pending.
- Latency: a frame accepted into an empty block gives o_dv = 1 with its first word on the next cycle (registered outputs, 1-cycle latency).
- Output handshake:
  - A word transfers on an edge where o_dv && i_ready.
  - With i_ready low, o_data/o_dv/o_last hold stable.
  - o_dv never drops mid-frame.
- Word order:
  - LITTLE_ENDIAN=1: words 0,1,...,n-1.
  - LITTLE_ENDIAN=0: words n-1,...,0.
- o_last is high exactly with the n-th emitted word.
- Last-word handshake:
  - If pending is valid, pending moves to active on the same edge; o_dv stays 1 and the first word of the next frame appears the next cycle (zero bubbles).
  - Else if a frame is accepted on that edge, it loads active with the same zero-bubble result.
  - Else o_dv = 0.
- Single-word frame (n = 1): o_dv and o_last both high for one transfer.
- o_data when idle: holds the last emitted value (0 after reset). Benches must not check it when o_dv = 0.
- o_busy = active_valid || pending_valid.
- Simultaneous accept + transfer: both occur on the same edge. Counters never wrap beyond n.

Test Plan:
- LE, i_data=32'h12345678, i_nwords=4, i_ready=1 -> o_data 78,56,34,12 on 4 consecutive cycles starting 1 cycle after accept; o_last only with 12; then o_dv=0.
- BE instance, same stimulus -> 12,34,56,78; o_last with 78. Partial frame i_nwords=2 -> BE 56,78; LE 78,56.
- Backpressure: LE full frame, i_ready low for 3 cycles after the first word -> word 56 held stable with o_dv=1 for 3 cycles; total 4 transfers, no loss or duplication.
- Back-to-back: frames 32'h12345678 then 32'hAABBCCDD offered with i_dv held, then a third frame.
  - 8 consecutive o_dv cycles, LE: 78,56,34,12,DD,CC,BB,AA.
  - o_ready low while pending is full.
  - Third frame accepted only after o_ready returns.
- Length clamp: i_nwords=0 and i_nwords=7 (NUM_WORDS=4) -> 4-word frames each.
- Reset mid-frame: assert i_reset_n low after the second word -> o_dv, o_last, o_busy, o_ready = 0 immediately (async). After release o_ready=1 next edge, no residual words. A fresh frame serializes correctly.
